adder_measure_sequencer: RTL and testbench
==========================================

// Module: adder_measure_sequencer
// PURPOSE
//  Initiator side of the instrumented adder measurement interface. Accepts a measurement command
//  (operands A/B, run window), drives operands and ring-run enable into the instrumented adder,
//  times the run window, samples sum and ring count, checks sum = A+B and returns a response.
//  Sits between the logic-analyser command registers and the instrumented adder, on wb_clk_i.
// PARAMETERS
//  WIDTH        32  operand / sum / ring-count width
//  WIN_W        16  run-window counter width
//  SETTLE_CYC    4  cycles operands are held stable before run enable rises (>=1)
//  DRAIN_CYC     2  cycles after run enable falls before sum/count are sampled (>=1)
// PORTS
//  wb_clk_i       in   1      system clock
//  wb_rst_i       in   1      synchronous active-high reset
//  cmd_valid      in   1      command offered
//  cmd_ready      out  1      sequencer can accept command
//  cmd_a          in   WIDTH  operand A
//  cmd_b          in   WIDTH  operand B
//  cmd_window     in   WIN_W  run-enable duration in cycles
//  add_a          out  WIDTH  operand A to adder
//  add_b          out  WIDTH  operand B to adder
//  add_run        out  1      ring-oscillator run enable
//  add_clr        out  1      one-cycle clear of adder ring counter
//  add_sum        in   WIDTH  adder sum output
//  add_count      in   WIDTH  adder ring counter (already synchronised to wb_clk_i)
//  rsp_valid      out  1      response available
//  rsp_ready      in   1      consumer accepts response
//  rsp_sum        out  WIDTH  sampled sum
//  rsp_count      out  WIDTH  sampled ring count
//  rsp_error      out  1      sampled sum != (cmd_a+cmd_b) mod 2^WIDTH
//  err_count      out  16     saturating mismatch count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state IDLE; cmd_ready=1, add_a=add_b=0, add_run=0, add_clr=0, rsp_valid=0,
//    rsp_sum=rsp_count=0, rsp_error=0, err_count=0. Reset mid-run drops add_run next cycle; no response.
//  - FSM: IDLE -> LOAD -> RUN -> DRAIN -> RESP -> IDLE.
//  - IDLE: cmd_ready=1. cmd_valid&cmd_ready latches A,B,window; add_a/add_b update next cycle;
//    add_clr=1 for exactly that first LOAD cycle. cmd_ready=0 in every other state.
//  - LOAD: hold SETTLE_CYC cycles, then RUN. add_run=1 for exactly window cycles (cycle-exact).
//  - window==0: RUN skipped, LOAD goes straight to DRAIN; add_run never rises.
//  - DRAIN: add_run=0, wait DRAIN_CYC cycles, then on the last DRAIN cycle register add_sum,
//    add_count, error flag into rsp_*; rsp_valid=1 next cycle (state RESP).
//  - Sum check: full WIDTH compare against (A+B) truncated to WIDTH; carry-out ignored.
//  - RESP: rsp_valid and rsp_* held stable until rsp_valid&rsp_ready; then IDLE, rsp_valid=0 next
//    cycle. No new command accepted in the handoff cycle (cmd_ready rises the cycle after).
//  - add_a/add_b hold last operands after completion (not cleared) until next command.
//  - Latency cmd handshake -> rsp_valid = 1 + SETTLE_CYC + window + DRAIN_CYC cycles.
// CONFIGURATION
//  SEQ_ERRCNT_EN defined: err_count increments on each response with rsp_error=1, at the
//   rsp_valid rise; saturates at 16'hFFFF; cleared only by wb_rst_i.
//  SEQ_ERRCNT_EN undefined: counter logic absent, err_count tied to 0; all else identical.
// TESTING
//  1 Reset: after wb_rst_i held 2 cycles -> all outputs at reset values, cmd_ready=1.
//  2 A=3,B=5,window=10, model add_sum=A+B, add_count=123 -> add_clr one pulse, add_run high
//    exactly 10 cycles, rsp_valid after 1+4+10+2=17 cycles, rsp_sum=8, rsp_count=123, rsp_error=0.
//  3 A=32'hFFFFFFFF,B=1, model sum=0 -> rsp_sum=0, rsp_error=0 (wrap); model sum=1 -> rsp_error=1,
//    err_count=1 with SEQ_ERRCNT_EN, 0 without.
//  4 window=0 -> add_run never asserted, rsp_valid after 7 cycles.
//  5 rsp_ready low 20 cycles, cmd_valid held high -> rsp_* stable, cmd_ready=0 throughout; after
//    accept, second command taken the cycle after cmd_ready rises.
//  6 wb_rst_i asserted during RUN -> add_run=0 next cycle, no rsp_valid, cmd_ready=1 after release.

Source files
------------

// File: rtl/adder_measure_sequencer.sv
// Initiator sequencer for the instrumented adder: loads operands, times the ring-run window,
// samples sum/count, checks sum against A+B and returns a response. Optional: SEQ_ERRCNT_EN.
module adder_measure_sequencer #(
  parameter int WIDTH      = 32,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [WIN_W-1:0] cmd_window,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_run,
  output logic             add_clr,
  input  logic [WIDTH-1:0] add_sum,
  input  logic [WIDTH-1:0] add_count,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic [WIDTH-1:0] rsp_count,
  output logic             rsp_error,
  output logic [15:0]      err_count
);

  localparam int PH_MAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int CNT_W  = (WIN_W > PH_W) ? WIN_W : PH_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIN_W-1:0] window_q;
  logic [WIDTH-1:0] exp_sum;
  logic             cnt_last;
  logic             accept;
  logic             capture;
  logic             mismatch;

  assign cnt_last = (cnt == '0);
  assign accept   = cmd_valid && cmd_ready;
  assign capture  = (state == S_DRAIN) && cnt_last;
  // Carry-out falls away because exp_sum is only WIDTH bits wide.
  assign exp_sum  = add_a + add_b;
  assign mismatch = (add_sum != exp_sum);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of the order the simulator evaluates processes.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    add_run   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (cnt_last) state_nxt = (window_q == '0) ? S_DRAIN : S_RUN;
      end
      S_RUN: begin
        add_run = 1'b1;
        if (cnt_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_last) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Phase down-counter: reloaded on each state entry, phase ends when it reaches zero.
  // LOAD spans the clear cycle plus SETTLE_CYC settle cycles.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt <= '0;
    end else if (state_nxt != state) begin
      unique case (state_nxt)
        S_LOAD:  cnt <= CNT_W'(SETTLE_CYC);
        S_RUN:   cnt <= CNT_W'(window_q) - CNT_W'(1);
        S_DRAIN: cnt <= CNT_W'(DRAIN_CYC - 1);
        default: cnt <= '0;
      endcase
    end else if (!cnt_last) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      add_a     <= '0;
      add_b     <= '0;
      window_q  <= '0;
      add_clr   <= 1'b0;
      rsp_sum   <= '0;
      rsp_count <= '0;
      rsp_error <= 1'b0;
    end else begin
      add_clr <= accept;
      if (accept) begin
        add_a    <= cmd_a;
        add_b    <= cmd_b;
        window_q <= cmd_window;
      end
      if (capture) begin
        rsp_sum   <= add_sum;
        rsp_count <= add_count;
        rsp_error <= mismatch;
      end
    end
  end

`ifdef SEQ_ERRCNT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      err_count <= '0;
    end else if (capture && mismatch && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Self-checking bench for adder_measure_sequencer: randomized commands, scoreboard queue,
// and a monitor that checks timing, response data and hold/handoff behaviour.
module tb_adder_measure_sequencer;

  localparam int WIDTH  = 32;
  localparam int WIN_W  = 16;
  localparam int SETTLE = 4;
  localparam int DRAIN  = 2;

  logic             clk = 1'b0;
  logic             wb_rst_i;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [WIN_W-1:0] cmd_window;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_run;
  logic             add_clr;
  logic [WIDTH-1:0] add_sum;
  logic [WIDTH-1:0] add_count;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic [WIDTH-1:0] rsp_count;
  logic             rsp_error;
  logic [15:0]      err_count;

  // Behavioural adder: true sum plus an injectable error term, and a fixed ring count.
  logic [WIDTH-1:0] sum_err;
  logic [WIDTH-1:0] count_val;
  assign add_sum   = add_a + add_b + sum_err;
  assign add_count = count_val;

  always #5 clk = ~clk;

  adder_measure_sequencer dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_window (cmd_window),
    .add_a      (add_a),
    .add_b      (add_b),
    .add_run    (add_run),
    .add_clr    (add_clr),
    .add_sum    (add_sum),
    .add_count  (add_count),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_count  (rsp_count),
    .rsp_error  (rsp_error),
    .err_count  (err_count)
  );

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    int               window;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] count;
    logic             error;
    longint           hs;
  } exp_t;

  exp_t   sb[$];
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  bit     stall    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Consumer: random back-pressure, or held off entirely while stall is set.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops on each response rise, checks it while held and after handoff.
  exp_t cur;
  bit   have_cur  = 1'b0;
  bit   post_acc  = 1'b0;
  int   run_cnt   = 0;
  int   clr_cnt   = 0;
  int   model_err = 0;

  always @(negedge clk) begin
    if (wb_rst_i) begin
      sb.delete();
      have_cur  = 1'b0;
      post_acc  = 1'b0;
      run_cnt   = 0;
      clr_cnt   = 0;
      model_err = 0;
    end else begin
      if (add_run) run_cnt++;
      if (add_clr) clr_cnt++;
      if (post_acc) begin
        check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        check("cmd_ready_after_handoff", 64'(cmd_ready), 64'd1);
        post_acc = 1'b0;
      end
      if (rsp_valid && !have_cur) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          cur      = sb.pop_front();
          have_cur = 1'b1;
          check("latency", 64'(cyc - cur.hs), 64'(1 + SETTLE + cur.window + DRAIN));
          check("run_cycles", 64'(run_cnt), 64'(cur.window));
          check("clr_pulses", 64'(clr_cnt), 64'd1);
          check("add_a_held", 64'(add_a), 64'(cur.a));
          check("add_b_held", 64'(add_b), 64'(cur.b));
          if (cur.error && model_err < 16'hFFFF) model_err++;
`ifdef SEQ_ERRCNT_EN
          check("err_count", 64'(err_count), 64'(model_err));
`else
          check("err_count", 64'(err_count), 64'd0);
`endif
          run_cnt = 0;
          clr_cnt = 0;
        end
      end
      if (have_cur) begin
        check("rsp_valid_hold", 64'(rsp_valid), 64'd1);
        check("rsp_sum", 64'(rsp_sum), 64'(cur.sum));
        check("rsp_count", 64'(rsp_count), 64'(cur.count));
        check("rsp_error", 64'(rsp_error), 64'(cur.error));
        check("cmd_ready_low_in_resp", 64'(cmd_ready), 64'd0);
        if (rsp_valid && rsp_ready) begin
          have_cur = 1'b0;
          post_acc = 1'b1;
        end
      end
    end
  end

  // Issue one command; the behavioural adder is only retargeted once the previous
  // measurement has been sampled (sequencer idle or presenting its response).
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int w,
                      input logic [WIDTH-1:0] serr, input logic [WIDTH-1:0] cnt);
    exp_t e;
    int   t;
    t = 0;
    while (!(cmd_ready || rsp_valid)) begin
      @(posedge clk);
      #1;
      if (++t > 500) begin
        fail_now("wait_idle_timeout");
        return;
      end
    end
    sum_err    = serr;
    count_val  = cnt;
    cmd_a      = a;
    cmd_b      = b;
    cmd_window = WIN_W'(w);
    cmd_valid  = 1'b1;
    t = 0;
    while (!cmd_ready) begin
      @(posedge clk);
      #1;
      if (++t > 500) begin
        fail_now("cmd_ready_timeout");
        cmd_valid = 1'b0;
        return;
      end
    end
    e.a      = a;
    e.b      = b;
    e.window = w;
    e.sum    = WIDTH'(longint'(a) + longint'(b) + longint'(serr));
    e.count  = cnt;
    e.error  = (e.sum != WIDTH'(longint'(a) + longint'(b)));
    e.hs     = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drained();
    int t;
    t = 0;
    while (sb.size() != 0 || have_cur) begin
      @(posedge clk);
      #1;
      if (++t > 2000) begin
        fail_now("drain_timeout");
        return;
      end
    end
  endtask

  initial begin
    int t;
    bit seen;
    wb_rst_i   = 1'b1;
    cmd_valid  = 1'b0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_window = '0;
    sum_err    = '0;
    count_val  = '0;
    repeat (2) @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("reset_cmd_ready", 64'(cmd_ready), 64'd1);
    check("reset_add_a", 64'(add_a), 64'd0);
    check("reset_add_b", 64'(add_b), 64'd0);
    check("reset_add_run", 64'(add_run), 64'd0);
    check("reset_add_clr", 64'(add_clr), 64'd0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    check("reset_rsp_count", 64'(rsp_count), 64'd0);
    check("reset_rsp_error", 64'(rsp_error), 64'd0);
    check("reset_err_count", 64'(err_count), 64'd0);

    // Directed: basic, wrap without error, wrap with error, zero window.
    send(32'd3, 32'd5, 10, 32'd0, 32'd123);
    send(32'hFFFF_FFFF, 32'd1, 6, 32'd0, 32'd9);
    send(32'hFFFF_FFFF, 32'd1, 3, 32'd1, 32'd10);
    send(32'd100, 32'd200, 0, 32'd0, 32'd77);
    wait_drained();

    // Long back-pressure with the next command already offered.
    stall = 1'b1;
    send(32'd11, 32'd22, 8, 32'd0, 32'd55);
    fork
      send(32'd33, 32'd44, 5, 32'd4, 32'd66);
      begin
        t = 0;
        while (!rsp_valid && t < 500) begin
          @(posedge clk);
          #1;
          t++;
        end
        repeat (20) @(posedge clk);
        #1;
        stall = 1'b0;
      end
    join
    wait_drained();

    for (int i = 0; i < 40; i++) begin
      send($urandom, $urandom, int'($urandom_range(0, 40)),
           ($urandom_range(0, 3) == 0) ? WIDTH'($urandom) : '0, $urandom);
    end
    wait_drained();

    // Reset in the middle of the run window.
    send($urandom, $urandom, 20, 32'd0, 32'd7);
    t = 0;
    while (!add_run && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("run_seen_before_reset", 64'(add_run), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    wb_rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("reset_run_drop", 64'(add_run), 64'd0);
    check("reset_run_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    wb_rst_i = 1'b0;
    @(posedge clk);
    #1;
    check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_reset", 64'(seen), 64'd0);

    send(32'd7, 32'd8, 2, 32'd1, 32'd99);
    wait_drained();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
